// File: rtl/lieat_ifu_fetchctl.sv
// Instruction-fetch sequencer: drives BPU fetch/flush controls, issues one fetch per PC to imem,
// and holds the returned word in the IR for decode. Handles JALR stalls, fence.i and EXU redirects.
module lieat_ifu_fetchctl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] bpu_pc,
    input  logic            bpu_prdt_taken,
    input  logic            bpu_jalr_need_wait,
    input  logic            bpu_need_fencei,
    output logic [XLEN-1:0] bpu_inst,
    output logic            bpu_rst_req,
    output logic            bpu_ifetch_req,
    output logic            bpu_flush_req,
    output logic [XLEN-1:0] bpu_flush_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_inst,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [XLEN-1:0] ir_inst,
    output logic [XLEN-1:0] ir_pc,
    output logic            ir_prdt_taken,
    input  logic            exu_flush_req,
    input  logic [XLEN-1:0] exu_flush_pc,
    input  logic            pipe_idle
);

    typedef enum logic [2:0] {
        StBoot,
        StReq,
        StResp,
        StHold,
        StFencei,
        StDrain
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [XLEN-1:0] r_ir_inst;
    logic [XLEN-1:0] r_ir_pc;
    logic            r_prdt;
    logic            w_flush;
    logic            w_ir_valid;
    logic            w_ld_pc;
    logic            w_ld_inst;
    logic            w_ld_prdt;

    assign w_flush    = exu_flush_req & (r_state != StBoot);
    assign w_ir_valid = (r_state == StHold) & ~bpu_jalr_need_wait & ~w_flush;

    always_comb begin
        w_state_nxt    = r_state;
        bpu_rst_req    = 1'b0;
        bpu_ifetch_req = 1'b0;
        bpu_flush_req  = 1'b0;
        bpu_flush_pc   = '0;
        imem_req_valid = 1'b0;
        w_ld_pc        = 1'b0;
        w_ld_inst      = 1'b0;
        w_ld_prdt      = 1'b0;
        unique case (r_state)
            StBoot: begin
                bpu_rst_req = ~rst;
                w_state_nxt = StReq;
            end
            StReq: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    w_ld_pc     = ~w_flush;
                    w_state_nxt = StResp;
                end
            end
            StResp: begin
                if (imem_rsp_valid) begin
                    w_ld_inst   = ~w_flush;
                    w_state_nxt = StHold;
                end
            end
            StHold: begin
                if (w_ir_valid && ir_ready) begin
                    w_ld_prdt = 1'b1;
                    if (bpu_need_fencei) begin
                        w_state_nxt = StFencei;
                    end else begin
                        bpu_ifetch_req = 1'b1;
                        w_state_nxt    = StReq;
                    end
                end
            end
            StFencei: begin
                if (pipe_idle) begin
                    bpu_flush_req = 1'b1;
                    bpu_flush_pc  = r_ir_pc + XLEN'(4);
                    w_state_nxt   = StReq;
                end
            end
            StDrain: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = StReq;
                end
            end
            default: w_state_nxt = StBoot;
        endcase
        // A redirect wins; drain only if a response is still owed to the flushed stream.
        if (w_flush) begin
            bpu_flush_req  = 1'b1;
            bpu_flush_pc   = exu_flush_pc;
            bpu_ifetch_req = 1'b0;
            if (((r_state == StResp) && !imem_rsp_valid) ||
                ((r_state == StReq) && imem_req_ready) ||
                ((r_state == StDrain) && !imem_rsp_valid)) begin
                w_state_nxt = StDrain;
            end else begin
                w_state_nxt = StReq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StBoot;
            r_ir_inst <= '0;
            r_ir_pc   <= '0;
            r_prdt    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld_pc) begin
                r_ir_pc <= bpu_pc;
            end
            if (w_ld_inst) begin
                r_ir_inst <= imem_rsp_inst;
            end
            if (w_ld_prdt) begin
                r_prdt <= bpu_prdt_taken;
            end
        end
    end

    assign imem_req_addr = bpu_pc;
    assign bpu_inst      = r_ir_inst;
    assign ir_inst       = r_ir_inst;
    assign ir_pc         = r_ir_pc;
    assign ir_valid      = w_ir_valid;
    // Prediction is live while the IR is offered, then frozen at the handshake.
    assign ir_prdt_taken = (r_state == StHold) ? bpu_prdt_taken : r_prdt;

endmodule

// File: tb/tb_lieat_ifu_fetchctl.sv
// Bench for lieat_ifu_fetchctl: directed test-plan steps, then randomized traffic checked against
// a transaction-level model (expected PC stream, held instruction, pending fence, owed responses).
module tb_lieat_ifu_fetchctl;

    localparam logic [31:0] RstVec = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bpu_pc;
    logic        bpu_prdt_taken;
    logic        bpu_jalr_need_wait;
    logic        bpu_need_fencei;
    logic [31:0] bpu_inst;
    logic        bpu_rst_req;
    logic        bpu_ifetch_req;
    logic        bpu_flush_req;
    logic [31:0] bpu_flush_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_inst;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_inst;
    logic [31:0] ir_pc;
    logic        ir_prdt_taken;
    logic        exu_flush_req;
    logic [31:0] exu_flush_pc;
    logic        pipe_idle;

    lieat_ifu_fetchctl #(.XLEN(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .bpu_pc            (bpu_pc),
        .bpu_prdt_taken    (bpu_prdt_taken),
        .bpu_jalr_need_wait(bpu_jalr_need_wait),
        .bpu_need_fencei   (bpu_need_fencei),
        .bpu_inst          (bpu_inst),
        .bpu_rst_req       (bpu_rst_req),
        .bpu_ifetch_req    (bpu_ifetch_req),
        .bpu_flush_req     (bpu_flush_req),
        .bpu_flush_pc      (bpu_flush_pc),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_inst     (imem_rsp_inst),
        .ir_valid          (ir_valid),
        .ir_ready          (ir_ready),
        .ir_inst           (ir_inst),
        .ir_pc             (ir_pc),
        .ir_prdt_taken     (ir_prdt_taken),
        .exu_flush_req     (exu_flush_req),
        .exu_flush_pc      (exu_flush_pc),
        .pipe_idle         (pipe_idle)
    );

    always #5 clk = ~clk;

    // BPU environment: PC register steered by the DUT's pulses.
    always @(posedge clk) begin
        if (rst) bpu_pc <= 32'h0;
        else if (bpu_rst_req) bpu_pc <= RstVec;
        else if (bpu_flush_req) bpu_pc <= bpu_flush_pc;
        else if (bpu_ifetch_req) bpu_pc <= bpu_pc + 32'h4;
    end

    typedef struct {
        logic [31:0] addr;
        int unsigned ep;
        int unsigned cyc;
    } req_t;

    req_t        q[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    bit          zero_wait = 1'b1;
    bit          rnd = 1'b0;
    logic        dir_fencei = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state
    bit          m_rst_prev = 1'b0;
    bit          m_boot = 1'b0;
    bit          m_held = 1'b0;
    bit          m_fence = 1'b0;
    logic        m_prdt = 1'b0;
    logic [31:0] m_held_pc = 32'h0;
    logic [31:0] m_fence_pc = 32'h0;
    logic [31:0] m_ref_pc = 32'h0;
    int unsigned m_epoch = 0;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model();
        logic exu, hs, exp_v, exp_if, ffire, exp_fl, exp_rq;
        req_t r;
        if (rst) begin
            if (m_rst_prev) begin
                chk1("rst_rst_req", bpu_rst_req, 1'b0);
                chk1("rst_req_valid", imem_req_valid, 1'b0);
                chk1("rst_ir_valid", ir_valid, 1'b0);
                chk1("rst_flush", bpu_flush_req, 1'b0);
                chk1("rst_ifetch", bpu_ifetch_req, 1'b0);
                chk32("rst_inst", bpu_inst, 32'h0);
                chk32("rst_ir_pc", ir_pc, 32'h0);
            end
            m_rst_prev = 1'b1;
            m_boot = 1'b1;
            m_held = 1'b0;
            m_fence = 1'b0;
            m_prdt = 1'b0;
            q.delete();
            return;
        end
        m_rst_prev = 1'b0;
        if (m_boot) begin
            chk1("boot_rst_req", bpu_rst_req, 1'b1);
            chk1("boot_req_valid", imem_req_valid, 1'b0);
            chk1("boot_ir_valid", ir_valid, 1'b0);
            chk1("boot_flush", bpu_flush_req, 1'b0);
            chk1("boot_ifetch", bpu_ifetch_req, 1'b0);
            m_boot = 1'b0;
            m_ref_pc = RstVec;
            return;
        end
        exu    = exu_flush_req;
        exp_v  = m_held & ~bpu_jalr_need_wait & ~exu;
        hs     = exp_v & ir_ready;
        exp_if = hs & ~bpu_need_fencei;
        ffire  = m_fence & pipe_idle & ~exu;
        exp_fl = exu | ffire;
        exp_rq = !m_held && !m_fence && (q.size() == 0);
        chk1("rst_req", bpu_rst_req, 1'b0);
        chk1("ir_valid", ir_valid, exp_v);
        chk1("ifetch_req", bpu_ifetch_req, exp_if);
        chk1("flush_req", bpu_flush_req, exp_fl);
        if (exp_fl) chk32("flush_pc", bpu_flush_pc, exu ? exu_flush_pc : m_fence_pc + 32'h4);
        chk1("req_valid", imem_req_valid, exp_rq);
        if (exp_rq) chk32("req_addr", imem_req_addr, bpu_pc);
        if (m_held) begin
            chk32("ir_pc", ir_pc, m_held_pc);
            chk32("bpu_inst", bpu_inst, hash(m_held_pc));
            chk32("ir_inst", ir_inst, hash(m_held_pc));
            chk1("prdt_live", ir_prdt_taken, bpu_prdt_taken);
        end else begin
            chk1("prdt_reg", ir_prdt_taken, m_prdt);
        end
        if (hs) begin
            m_held = 1'b0;
            m_prdt = bpu_prdt_taken;
            if (bpu_need_fencei) begin
                m_fence = 1'b1;
                m_fence_pc = m_held_pc;
            end else begin
                m_ref_pc = m_held_pc + 32'h4;
            end
        end
        if (ffire) begin
            m_fence = 1'b0;
            m_ref_pc = m_fence_pc + 32'h4;
        end
        // A response is usable only if no redirect hit between its acceptance and its arrival.
        if (imem_rsp_valid && q.size() > 0) begin
            r = q.pop_front();
            if (r.ep == m_epoch && !exu) begin
                m_held = 1'b1;
                m_held_pc = r.addr;
                chk32("fetch_pc", r.addr, m_ref_pc);
            end
        end
        if (imem_req_valid === 1'b1 && imem_req_ready) begin
            q.push_back('{addr: imem_req_addr, ep: m_epoch, cyc: cyc});
        end
        if (exu) begin
            m_epoch++;
            m_held = 1'b0;
            m_fence = 1'b0;
            m_ref_pc = exu_flush_pc;
        end
    endtask

    task automatic cyc_a();
        bpu_need_fencei = rnd ? (bpu_inst[2:0] == 3'b101) : dir_fencei;
        imem_rsp_valid = 1'b0;
        imem_rsp_inst = 32'h0;
        if (q.size() > 0) begin
            if (cyc >= q[0].cyc + lat && (zero_wait || $urandom_range(0, 1) == 1)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_inst = hash(q[0].addr);
            end
        end
        imem_req_ready = zero_wait ? 1'b1 : ($urandom_range(0, 2) != 0);
        @(negedge clk);
        model();
    endtask

    task automatic cyc_b();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        cyc_a();
        cyc_b();
    endtask

    // Advance until the IR is offered (bounded); leaves the run at the sample point of that cycle.
    task automatic wait_ir(input string tag, input logic [31:0] pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc_a();
            if (ir_valid === 1'b1) found = 1'b1;
            else cyc_b();
        end
        chk1({tag, "_seen"}, found, 1'b1);
        chk32({tag, "_pc"}, ir_pc, pc);
    endtask

    initial begin
        rst = 1'b1;
        bpu_prdt_taken = 1'b0;
        bpu_jalr_need_wait = 1'b0;
        bpu_need_fencei = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_inst = 32'h0;
        ir_ready = 1'b0;
        exu_flush_req = 1'b0;
        exu_flush_pc = 32'h0;
        pipe_idle = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;

        // Reset release timing with zero-wait imem
        cyc_a(); chk1("c1_rst_req", bpu_rst_req, 1'b1); cyc_b();
        cyc_a(); chk1("c2_req", imem_req_valid, 1'b1); chk32("c2_addr", imem_req_addr, RstVec);
        cyc_b();
        step();
        // Decode back-pressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            cyc_a();
            chk1("hold_valid", ir_valid, 1'b1);
            chk32("hold_pc", ir_pc, RstVec);
            chk1("hold_no_ifetch", bpu_ifetch_req, 1'b0);
            chk32("hold_inst", bpu_inst, hash(RstVec));
            cyc_b();
        end
        ir_ready = 1'b1;
        cyc_a(); chk1("ready_ifetch", bpu_ifetch_req, 1'b1); cyc_b();

        // JALR wait for 3 cycles in HOLD
        bpu_jalr_need_wait = 1'b1;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            cyc_a();
            chk1("jalr_valid", ir_valid, 1'b0);
            chk32("jalr_inst", bpu_inst, hash(32'h8000_0004));
            cyc_b();
        end
        bpu_jalr_need_wait = 1'b0;
        cyc_a(); chk1("jalr_release", ir_valid, 1'b1); chk1("jalr_ifetch", bpu_ifetch_req, 1'b1);
        cyc_b();
        wait_ir("i08", 32'h8000_0008); cyc_b();
        wait_ir("i0c", 32'h8000_000C); cyc_b();

        // fence.i with pipe busy for 4 cycles
        dir_fencei = 1'b1;
        pipe_idle = 1'b0;
        wait_ir("fence", 32'h8000_0010);
        chk1("fence_no_ifetch", bpu_ifetch_req, 1'b0);
        cyc_b();
        dir_fencei = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc_a(); chk1("fence_wait", bpu_flush_req, 1'b0); cyc_b();
        end
        pipe_idle = 1'b1;
        cyc_a(); chk1("fence_flush", bpu_flush_req, 1'b1);
        chk32("fence_pc", bpu_flush_pc, 32'h8000_0014);
        cyc_b();
        wait_ir("i14", 32'h8000_0014); cyc_b();

        // Redirect in RESP, stale response 2 cycles later is drained
        lat = 3;
        step();
        exu_flush_req = 1'b1;
        exu_flush_pc = 32'h8000_0100;
        cyc_a(); chk1("drain_flush", bpu_flush_req, 1'b1);
        chk32("drain_flush_pc", bpu_flush_pc, 32'h8000_0100);
        cyc_b();
        exu_flush_req = 1'b0;
        step();
        cyc_a(); chk1("drain_rsp", imem_rsp_valid, 1'b1); chk1("drain_noreq", imem_req_valid, 1'b0);
        chk32("drain_keep_inst", bpu_inst, hash(32'h8000_0014));
        cyc_b();
        lat = 1;
        cyc_a(); chk1("drain_req", imem_req_valid, 1'b1);
        chk32("drain_addr", imem_req_addr, 32'h8000_0100);
        cyc_b();
        wait_ir("i100", 32'h8000_0100);
        chk32("i100_inst", bpu_inst, hash(32'h8000_0100));
        cyc_b();

        // Redirect coincident with request acceptance: drain entered
        exu_flush_req = 1'b1;
        exu_flush_pc = 32'h8000_0200;
        cyc_a(); chk1("acc_flush", bpu_flush_req, 1'b1); chk1("acc_req", imem_req_valid, 1'b1);
        cyc_b();
        exu_flush_req = 1'b0;
        cyc_a(); chk1("acc_drain_noreq", imem_req_valid, 1'b0); cyc_b();
        cyc_a(); chk32("acc_addr", imem_req_addr, 32'h8000_0200); cyc_b();
        // Redirect coincident with the response: no drain
        exu_flush_req = 1'b1;
        exu_flush_pc = 32'h8000_0300;
        cyc_a(); chk1("rsp_flush_rsp", imem_rsp_valid, 1'b1);
        chk32("rsp_flush_pc", bpu_flush_pc, 32'h8000_0300);
        cyc_b();
        exu_flush_req = 1'b0;
        cyc_a(); chk1("rsp_req", imem_req_valid, 1'b1);
        chk32("rsp_addr", imem_req_addr, 32'h8000_0300);
        cyc_b();
        wait_ir("i300", 32'h8000_0300);
        chk32("i300_inst", bpu_inst, hash(32'h8000_0300));
        cyc_b();

        // Randomized traffic, with one reset mid-run
        rnd = 1'b1;
        zero_wait = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = (i >= 1500 && i < 1503);
            ir_ready = 1'($urandom_range(0, 1));
            bpu_jalr_need_wait = ($urandom_range(0, 3) == 0);
            bpu_prdt_taken = 1'($urandom_range(0, 1));
            pipe_idle = ($urandom_range(0, 2) == 0);
            exu_flush_req = ($urandom_range(0, 15) == 0);
            exu_flush_pc = {16'h8000, 14'($urandom), 2'b00};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lieat_ifu_fetchctl.md
# lieat_ifu_fetchctl

Instruction-fetch sequencer between the IFU branch-prediction unit and instruction memory. Drives the BPU's fetch/reset/flush controls, issues one outstanding fetch per PC to instruction memory, holds the returned word in the instruction register (IR) for decode, and presents it back to the BPU's decoder. Also handles JALR-dependency stalls, fence.i draining, and EXU redirect with discard of in-flight responses.

## Interface
- XLEN, 32, datapath / PC width
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- bpu_pc  in  XLEN  current fetch PC from BPU
- bpu_prdt_taken  in  1  BPU prediction for the IR instruction
- bpu_jalr_need_wait  in  1  JALR source not ready
- bpu_need_fencei  in  1  IR holds fence.i
- bpu_inst  out  XLEN  IR contents fed to BPU decoder
- bpu_rst_req  out  1  load reset vector
- bpu_ifetch_req  out  1  advance PC at next edge
- bpu_flush_req  out  1  redirect PC at next edge
- bpu_flush_pc  out  XLEN  redirect target
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  request accepted
- imem_req_addr  out  XLEN  fetch address (= bpu_pc)
- imem_rsp_valid  in  1  response valid (exactly one per accepted request, ≥1 cycle later)
- imem_rsp_inst  in  XLEN  response data
- ir_valid  out  1  IR offered to decode
- ir_ready  in  1  decode accepts IR
- ir_inst  out  XLEN  instruction
- ir_pc  out  XLEN  PC of instruction
- ir_prdt_taken  out  1  registered prediction
- exu_flush_req  in  1  EXU redirect
- exu_flush_pc  in  XLEN  EXU redirect target
- pipe_idle  in  1  downstream pipeline and store path empty

## Operation
- States: BOOT, REQ, RESP, HOLD, FENCEI, DRAIN.
- BOOT (reset state): on first cycle with rst low, assert bpu_rst_req for 1 cycle, go to REQ.
- REQ: imem_req_valid=1, imem_req_addr=bpu_pc. On imem_req_ready, latch ir_pc<=bpu_pc and go to RESP.
- RESP: on imem_rsp_valid, ir_inst<=imem_rsp_inst and go to HOLD.
- HOLD: ir_valid = ~bpu_jalr_need_wait. ir_prdt_taken follows bpu_prdt_taken combinationally, registered at handshake.
  - On ir_valid & ir_ready with ~bpu_need_fencei: bpu_ifetch_req=1 this cycle, go to REQ.
  - With bpu_need_fencei: no ifetch_req; go to FENCEI.
- FENCEI: wait for pipe_idle, then assert bpu_flush_req=1 with bpu_flush_pc=ir_pc+4 (mod 2^XLEN) for 1 cycle, go to REQ.
- exu_flush_req (any state except BOOT) has priority over everything:
  - bpu_flush_req=1, bpu_flush_pc=exu_flush_pc; bpu_ifetch_req suppressed; ir_valid forced 0 that cycle.
  - Next state: DRAIN if a request is outstanding (RESP without imem_rsp_valid this cycle, or REQ with imem_req_ready this cycle); otherwise REQ.
- DRAIN: discard the next imem_rsp_valid, then go to REQ. A further exu_flush_req in DRAIN re-drives the BPU flush and stays in DRAIN.
- bpu_inst = ir_inst at all times, so the decoder sees the held word during stalls.

## Timing
- Reset values: state=BOOT, all outputs 0, ir_inst=ir_pc=0.
- Latency: BOOT→REQ 1 cycle. With zero-wait imem (ready same cycle, rsp next cycle), REQ→RESP→HOLD gives 3 cycles per instruction: REQ, RESP, HOLD with ir_valid.
- bpu_ifetch_req and bpu_flush_req are single-cycle pulses and never asserted together.
- imem_req_valid stays high until ready; the address is stable because the PC only changes on ifetch/flush.
- fence.i: flush is issued in the first cycle pipe_idle=1, no earlier.
- rst asserted mid-transaction: return to BOOT next edge. Any outstanding response is not tracked; the memory is reset with the same signal.

## Test plan
- Reset release, imem zero-wait, bpu_pc=0x80000000 → bpu_rst_req pulse at cycle 1; imem_req_addr=0x80000000 at cycle 2; ir_valid with ir_pc=0x80000000 at cycle 4.
- Decode holds ir_ready=0 for 5 cycles → ir_inst stable, no bpu_ifetch_req; ifetch pulse on the cycle ready rises.
- bpu_jalr_need_wait=1 for 3 cycles in HOLD → ir_valid=0 for those cycles, bpu_inst unchanged; handshake when wait drops.
- fence.i at ir_pc=0x80000010, pipe_idle low for 4 cycles → single bpu_flush_req with flush_pc=0x80000014 in the cycle pipe_idle rises.
- exu_flush_req (pc=0x80000100) in RESP, response 2 cycles later → DRAIN discards the response; next imem request uses the new bpu_pc; ir_inst not overwritten by the stale data.
- exu_flush_req in the same cycle as REQ acceptance or as the response → DRAIN entered or not entered respectively; exactly one response is discarded.
